// File: rtl/g_debncn.sv
// Synchronizer + glitch filter for a raw active-low input; clean level QN plus FALL/RISE strobes.
// Latency: an AN edge set up before edge 1 reaches QN at edge SYNC_STAGES+FILT_CNT (CE held high).
// Backpressure: none; CE only stalls qualification, the synchronizer always shifts.
module g_debncn #(
    parameter int SYNC_STAGES = 2,
    parameter int FILT_CNT    = 8,
    parameter int CNT_W       = 4
) (
    input  logic CK,
    input  logic CD,
    input  logic CE,
    input  logic AN,
    output logic QN,
    output logic FALL,
    output logic RISE,
    output logic BUSY
);

    // IDLE: synchronized input agrees with QN. QUAL: a change is pending.
    typedef enum logic {
        IDLE = 1'b0,
        QUAL = 1'b1
    } state_t;

    // Terminal count: the change is accepted on the edge where cnt already holds FILT_CNT-1,
    // so cnt never exceeds this value and cannot wrap.
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(FILT_CNT - 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    logic [SYNC_STAGES-1:0] sync;
    logic                   s;
    state_t                 state;
    logic [CNT_W-1:0]       cnt;
    logic [CNT_W-1:0]       cnt_nxt;
    logic                   qn_nxt;
    logic                   fall_nxt;
    logic                   rise_nxt;

    // Metastability chain; resets to the deasserted (high) level.
    always_ff @(posedge CK or posedge CD) begin
        if (CD) begin
            sync <= '1;
        end else begin
            sync <= {sync[SYNC_STAGES-2:0], AN};
        end
    end

    assign s     = sync[SYNC_STAGES-1];
    assign state = (s != QN) ? QUAL : IDLE;

    // Qualification decision: count enabled disagreeing edges, commit on the last one.
    always_comb begin
        cnt_nxt  = '0;
        qn_nxt   = QN;
        fall_nxt = 1'b0;
        rise_nxt = 1'b0;
        case (state)
            IDLE: begin
                // Any agreement discards partial qualification.
                cnt_nxt = '0;
            end
            QUAL: begin
                if (CE) begin
                    if (cnt == CNT_LAST) begin
                        qn_nxt   = s;
                        fall_nxt = ~s;
                        rise_nxt = s;
                        cnt_nxt  = '0;
                    end else begin
                        cnt_nxt = cnt + CNT_ONE;
                    end
                end else begin
                    cnt_nxt = cnt;
                end
            end
            default: begin
                cnt_nxt = '0;
            end
        endcase
    end

    // Output level, strobes and counter; reset drops everything immediately.
    always_ff @(posedge CK or posedge CD) begin
        if (CD) begin
            QN   <= 1'b1;
            FALL <= 1'b0;
            RISE <= 1'b0;
            cnt  <= '0;
        end else begin
            QN   <= qn_nxt;
            FALL <= fall_nxt;
            RISE <= rise_nxt;
            cnt  <= cnt_nxt;
        end
    end

    assign BUSY = (cnt != '0);

endmodule

// File: tb/tb_g_debncn.sv
// Bench for g_debncn: default instance (2 stages, filter 8) and a corner instance (3 stages, filter 1).
// Both share stimulus; a behavioural model checks every cycle, directed loops pin literal edge numbers.
// Inputs change 1ns after the rising edge; outputs are read on the falling edge or 1ns after rising.
module tb_g_debncn;

    logic CK;
    logic CD;
    logic CE;
    logic AN;
    logic qn_a, fall_a, rise_a, busy_a;
    logic qn_b, fall_b, rise_b, busy_b;

    int n_err = 0;
    int n_chk = 0;
    bit chk_en = 1'b0;

    g_debncn #(.SYNC_STAGES(2), .FILT_CNT(8), .CNT_W(4)) u_dut_a (
        .CK(CK), .CD(CD), .CE(CE), .AN(AN),
        .QN(qn_a), .FALL(fall_a), .RISE(rise_a), .BUSY(busy_a)
    );

    g_debncn #(.SYNC_STAGES(3), .FILT_CNT(1), .CNT_W(4)) u_dut_b (
        .CK(CK), .CD(CD), .CE(CE), .AN(AN),
        .QN(qn_b), .FALL(fall_b), .RISE(rise_b), .BUSY(busy_b)
    );

    initial CK = 1'b0;
    always #5 CK = ~CK;

    // Model: a history of AN samples, the output level, and the length of the current
    // run of enabled edges on which the delayed input disagreed with the output.
    typedef struct {
        logic [7:0] sh;
        logic       qn;
        int         run;
        logic       fall;
        logic       rise;
    } model_t;

    model_t ma, mb;

    function automatic model_t reset_m();
        model_t r;
        r.sh   = '1;
        r.qn   = 1'b1;
        r.run  = 0;
        r.fall = 1'b0;
        r.rise = 1'b0;
        return r;
    endfunction

    function automatic model_t step(model_t m, int ss, int fc, logic an, logic ce);
        model_t r;
        logic   sv;
        r      = m;
        sv     = m.sh[ss-1];
        r.sh   = {m.sh[6:0], an};
        r.fall = 1'b0;
        r.rise = 1'b0;
        if (sv == m.qn) begin
            r.run = 0;
        end else if (ce) begin
            r.run = m.run + 1;
            if (r.run >= fc) begin
                r.qn   = sv;
                r.run  = 0;
                r.fall = !sv;
                r.rise = sv;
            end
        end
        return r;
    endfunction

    // Advance both models on each clock edge; clear them as soon as CD rises.
    always @(posedge CK or posedge CD) begin
        if (CD) begin
            ma = reset_m();
            mb = reset_m();
        end else begin
            ma = step(ma, 2, 8, AN, CE);
            mb = step(mb, 3, 1, AN, CE);
        end
    end

    task automatic chk(input string nm, input logic act, input logic exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s at %0t: got %b expected %b", nm, $time, act, exp);
        end
    endtask

    // Every-cycle comparison of both instances against the model.
    always @(negedge CK) begin
        if (chk_en) begin
            chk("mdl_A_QN",   qn_a,   ma.qn);
            chk("mdl_A_FALL", fall_a, ma.fall);
            chk("mdl_A_RISE", rise_a, ma.rise);
            chk("mdl_A_BUSY", busy_a, ma.run != 0);
            chk("mdl_B_QN",   qn_b,   mb.qn);
            chk("mdl_B_FALL", fall_b, mb.fall);
            chk("mdl_B_RISE", rise_b, mb.rise);
            chk("mdl_B_BUSY", busy_b, mb.run != 0);
        end
    end

    task automatic edge_go();
        @(posedge CK);
        #1;
    endtask

    task automatic chk_a(input string nm, input logic q, input logic f, input logic r, input logic b);
        chk({nm, "_A_QN"},   qn_a,   q);
        chk({nm, "_A_FALL"}, fall_a, f);
        chk({nm, "_A_RISE"}, rise_a, r);
        chk({nm, "_A_BUSY"}, busy_a, b);
    endtask

    task automatic settle(input int n);
        AN = 1'b1;
        CE = 1'b1;
        repeat (n) edge_go();
    endtask

    initial begin
        CD = 1'b1;
        AN = 1'b1;
        CE = 1'b1;
        repeat (3) edge_go();
        chk_en = 1'b1;
        chk_a("rst", 1'b1, 1'b0, 1'b0, 1'b0);
        chk("rst_B_QN", qn_b, 1'b1);

        // Reset release and idle.
        CD = 1'b0;
        for (int k = 1; k <= 50; k++) begin
            edge_go();
            chk_a("idle", 1'b1, 1'b0, 1'b0, 1'b0);
        end

        // Clean assert then release.
        AN = 1'b0;
        for (int k = 1; k <= 12; k++) begin
            edge_go();
            chk_a("assert", (k >= 10) ? 1'b0 : 1'b1, k == 10, 1'b0, (k >= 3 && k <= 9));
            chk("assert_B_QN",   qn_b,   (k >= 4) ? 1'b0 : 1'b1);
            chk("assert_B_FALL", fall_b, k == 4);
        end
        AN = 1'b1;
        for (int k = 1; k <= 12; k++) begin
            edge_go();
            chk_a("release", (k >= 10) ? 1'b1 : 1'b0, 1'b0, k == 10, (k >= 3 && k <= 9));
            chk("release_B_RISE", rise_b, k == 4);
        end
        settle(4);

        // Glitch of 5 cycles is discarded.
        AN = 1'b0;
        for (int k = 1; k <= 14; k++) begin
            edge_go();
            chk_a("glitch5", 1'b1, 1'b0, 1'b0, (k >= 3 && k <= 7));
            if (k == 5) AN = 1'b1;
        end
        settle(4);

        // 8-cycle low pulse is accepted, then released.
        AN = 1'b0;
        for (int k = 1; k <= 22; k++) begin
            edge_go();
            chk_a("pulse8", (k >= 10 && k < 18) ? 1'b0 : 1'b1, k == 10, k == 18,
                  (k >= 3 && k <= 9) || (k >= 11 && k <= 17));
            if (k == 8) AN = 1'b1;
        end
        settle(4);

        // CE gap holds the count; QN falls 16 edges after the AN edge.
        AN = 1'b0;
        for (int k = 1; k <= 18; k++) begin
            edge_go();
            chk_a("ce_gap", (k >= 16) ? 1'b0 : 1'b1, k == 16, 1'b0, (k >= 3 && k <= 15));
            if (k == 6)  CE = 1'b0;
            if (k == 12) CE = 1'b1;
        end
        settle(14);

        // Async reset mid-qualification, AN held low throughout.
        AN = 1'b0;
        for (int k = 1; k <= 6; k++) begin
            edge_go();
        end
        chk("pre_cd_A_BUSY", busy_a, 1'b1);
        chk("pre_cd_B_QN",   qn_b,   1'b0);
        CD = 1'b1;
        #1;
        chk("cd_A_QN",   qn_a,   1'b1);
        chk("cd_A_BUSY", busy_a, 1'b0);
        chk("cd_B_QN",   qn_b,   1'b1);
        #1;
        CD = 1'b0;
        for (int k = 1; k <= 12; k++) begin
            edge_go();
            chk_a("post_cd", (k >= 10) ? 1'b0 : 1'b1, k == 10, 1'b0, (k >= 3 && k <= 9));
            chk("post_cd_B_FALL", fall_b, k == 4);
        end
        settle(14);

        // AN toggling every cycle never qualifies at filter 8.
        for (int k = 1; k <= 30; k++) begin
            AN = ~AN;
            edge_go();
            chk("toggle_A_QN",   qn_a,   1'b1);
            chk("toggle_A_FALL", fall_a, 1'b0);
            chk("toggle_A_RISE", rise_a, 1'b0);
        end
        settle(14);
        chk_a("end", 1'b1, 1'b0, 1'b0, 1'b0);

        chk_en = 1'b0;
        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
